// File: rtl/aha_tlx_pulse_sched_pkg.sv
// rtl/aha_tlx_pulse_sched_pkg.sv - shared types and parameter helpers for the TLX pulse scheduler
package aha_tlx_pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int MIN_REQ = 2;
  localparam int MAX_REQ = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit id_w_ok(input int num_req, input int id_w);
    return (num_req >= MIN_REQ) && (num_req <= MAX_REQ) && (id_w == clog2(num_req));
  endfunction

endpackage

// File: rtl/aha_tlx_pulse_sched_if.sv
// rtl/aha_tlx_pulse_sched_if.sv - request/event bundle between requesters and the pulse scheduler
interface aha_tlx_pulse_sched_if
  import aha_tlx_pulse_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = clog2(NUM_REQ),
  parameter int DROP_CNT_W = 8
);

  logic                  ENABLE;
  logic [NUM_REQ-1:0]    REQ_PULSE;
  logic                  DROP_CLR;
  logic                  SYNC_EVENT;
  logic [ID_W-1:0]       SYNC_ID;
  logic                  SYNC_BUSY;
  logic [NUM_REQ-1:0]    PENDING;
  logic [NUM_REQ-1:0]    DROP_STICKY;
  logic [DROP_CNT_W-1:0] DROP_COUNT;

  modport master (
    output ENABLE, REQ_PULSE, DROP_CLR,
    input  SYNC_EVENT, SYNC_ID, SYNC_BUSY, PENDING, DROP_STICKY, DROP_COUNT
  );

  modport slave (
    input  ENABLE, REQ_PULSE, DROP_CLR,
    output SYNC_EVENT, SYNC_ID, SYNC_BUSY, PENDING, DROP_STICKY, DROP_COUNT
  );

endinterface

// File: rtl/aha_tlx_rr_pick.sv
// rtl/aha_tlx_rr_pick.sv - round-robin pick of the first set request at or above the pointer
module aha_tlx_rr_pick
  import aha_tlx_pulse_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    grant_o,
  output logic               valid_o
);

  logic [ID_W:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending index is the final winner.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (req_i[idx[ID_W-1:0]]) begin
        grant_o = idx[ID_W-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aha_tlx_pulse_sched.sv
// rtl/aha_tlx_pulse_sched.sv - serializes requester pulses onto one spaced TLX sync pulse with ID qualifier
module aha_tlx_pulse_sched
  import aha_tlx_pulse_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int GAP_CYCLES = 8,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  aha_tlx_pulse_sched_if.slave  bus
);

  localparam int CNT_W = clog2(GAP_CYCLES + 1);

  if (!id_w_ok(NUM_REQ, ID_W)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ) with NUM_REQ in 2..16");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be at least 1");
  end

  state_t                state_q;
  logic                  evt_q;
  logic                  busy_q;
  logic [ID_W-1:0]       id_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       ptr_d;
  logic [CNT_W-1:0]      gap_q;
  logic [NUM_REQ-1:0]    pend_q;
  logic [NUM_REQ-1:0]    pend_d;
  logic [NUM_REQ-1:0]    sticky_q;
  logic [NUM_REQ-1:0]    sticky_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d;

  logic [ID_W-1:0]       win_id;
  logic                  win_vld;
  logic                  arb_slot;
  logic                  fire_go;
  logic [NUM_REQ-1:0]    grant_mask;
  logic [NUM_REQ-1:0]    drop_vec;

  aha_tlx_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i   (pend_q),
    .ptr_i   (ptr_q),
    .grant_o (win_id),
    .valid_o (win_vld)
  );

  // A grant can only be issued from IDLE or on the last GAP cycle, so pulses never come closer than 1+GAP_CYCLES.
  always_comb begin
    arb_slot = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_q == '0));
    fire_go  = arb_slot && bus.ENABLE && win_vld;
    grant_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_mask[i] = fire_go && (win_id == ID_W'(i));
    end
    ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
  end

  // A pulse on the bit being granted this cycle re-arms it rather than counting as a drop.
  always_comb begin
    pend_d   = (pend_q & ~grant_mask) | bus.REQ_PULSE;
    drop_vec = bus.REQ_PULSE & pend_q & ~grant_mask;
    sticky_d = bus.DROP_CLR ? drop_vec : (sticky_q | drop_vec);
    if (|drop_vec) begin
      if (bus.DROP_CLR) begin
        drop_cnt_d = DROP_CNT_W'(1);
      end else if (&drop_cnt_q) begin
        drop_cnt_d = drop_cnt_q;
      end else begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end else begin
      drop_cnt_d = bus.DROP_CLR ? '0 : drop_cnt_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      evt_q      <= 1'b0;
      busy_q     <= 1'b0;
      id_q       <= '0;
      ptr_q      <= '0;
      gap_q      <= '0;
      pend_q     <= '0;
      sticky_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      sticky_q   <= sticky_d;
      drop_cnt_q <= drop_cnt_d;
      evt_q      <= fire_go;
      if (fire_go) begin
        id_q  <= win_id;
        ptr_q <= ptr_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (fire_go) begin
            state_q <= ST_FIRE;
            busy_q  <= 1'b1;
          end
        end
        ST_FIRE: begin
          state_q <= ST_GAP;
          gap_q   <= CNT_W'(GAP_CYCLES - 1);
        end
        ST_GAP: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - CNT_W'(1);
          end else if (fire_go) begin
            state_q <= ST_FIRE;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SYNC_EVENT  = evt_q;
  assign bus.SYNC_ID     = id_q;
  assign bus.SYNC_BUSY   = busy_q;
  assign bus.PENDING     = pend_q;
  assign bus.DROP_STICKY = sticky_q;
  assign bus.DROP_COUNT  = drop_cnt_q;

endmodule

// File: tb/tb_aha_tlx_pulse_sched.sv
// tb/tb_aha_tlx_pulse_sched.sv - directed self-checking bench for the TLX pulse scheduler
module tb_aha_tlx_pulse_sched;

  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int GAP_CYCLES = 8;
  localparam int DROP_CNT_W = 8;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  aha_tlx_pulse_sched_if #(
    .NUM_REQ    (NUM_REQ),
    .ID_W       (ID_W),
    .DROP_CNT_W (DROP_CNT_W)
  ) bus ();

  aha_tlx_pulse_sched #(
    .NUM_REQ    (NUM_REQ),
    .ID_W       (ID_W),
    .GAP_CYCLES (GAP_CYCLES),
    .DROP_CNT_W (DROP_CNT_W)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench 1 time unit after a rising edge: that cycle is cycle 0 of the next test.
  task automatic apply_reset();
    RESET         = 1'b1;
    bus.ENABLE    = 1'b0;
    bus.REQ_PULSE = '0;
    bus.DROP_CLR  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET         = 1'b1;
    bus.ENABLE    = 1'b1;
    bus.REQ_PULSE = 4'b1111;
    bus.DROP_CLR  = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.SYNC_EVENT !== 1'b0) begin errors++; $display("FAIL reset_event: got %0b expected 0", bus.SYNC_EVENT); end
    checks++; if (bus.SYNC_ID !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", bus.SYNC_ID); end
    checks++; if (bus.SYNC_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.SYNC_BUSY); end
    checks++; if (bus.PENDING !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", bus.PENDING); end
    checks++; if (bus.DROP_STICKY !== 4'b0000) begin errors++; $display("FAIL reset_sticky: got %b expected 0000", bus.DROP_STICKY); end
    checks++; if (bus.DROP_COUNT !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.DROP_COUNT); end
  endtask

  task automatic test_single();
    apply_reset();
    bus.ENABLE = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      bus.REQ_PULSE = (c == 0) ? 4'b0100 : 4'b0000;
      @(negedge CLK);
      checks++; if (bus.SYNC_EVENT !== (c == 2)) begin errors++; $display("FAIL single_event c%0d: got %0b expected %0b", c, bus.SYNC_EVENT, (c == 2)); end
      checks++; if (bus.SYNC_BUSY !== (c >= 2 && c <= 10)) begin errors++; $display("FAIL single_busy c%0d: got %0b expected %0b", c, bus.SYNC_BUSY, (c >= 2 && c <= 10)); end
      if (c == 1) begin
        checks++; if (bus.PENDING !== 4'b0100) begin errors++; $display("FAIL single_pending c1: got %b expected 0100", bus.PENDING); end
      end
      if (c >= 2 && c <= 12) begin
        checks++; if (bus.SYNC_ID !== 2'd2) begin errors++; $display("FAIL single_id c%0d: got %0d expected 2", c, bus.SYNC_ID); end
      end
      tick();
    end
  endtask

  task automatic test_all_four();
    logic [ID_W-1:0] exp_id;
    apply_reset();
    bus.ENABLE = 1'b1;
    for (int c = 0; c <= 31; c++) begin
      bus.REQ_PULSE = (c == 0) ? 4'b1111 : 4'b0000;
      @(negedge CLK);
      checks++; if (bus.SYNC_EVENT !== (c == 2 || c == 11 || c == 20 || c == 29)) begin errors++; $display("FAIL all_event c%0d: got %0b", c, bus.SYNC_EVENT); end
      if (c == 2 || c == 11 || c == 20 || c == 29) begin
        exp_id = ID_W'((c - 2) / 9);
        checks++; if (bus.SYNC_ID !== exp_id) begin errors++; $display("FAIL all_id c%0d: got %0d expected %0d", c, bus.SYNC_ID, exp_id); end
      end
      if (c == 1) begin
        checks++; if (bus.PENDING !== 4'b1111) begin errors++; $display("FAIL all_pending c1: got %b expected 1111", bus.PENDING); end
      end
      if (c >= 30) begin
        checks++; if (bus.PENDING !== 4'b0000) begin errors++; $display("FAIL all_pending c%0d: got %b expected 0000", c, bus.PENDING); end
      end
      tick();
    end
  endtask

  task automatic test_drop_enable();
    logic [7:0] exp_cnt;
    int events;
    events = 0;
    apply_reset();
    for (int c = 0; c <= 22; c++) begin
      bus.ENABLE    = (c >= 10);
      bus.REQ_PULSE = (c == 0 || c == 3 || c == 5) ? 4'b0010 : 4'b0000;
      @(negedge CLK);
      exp_cnt = (c >= 6) ? 8'd2 : ((c >= 4) ? 8'd1 : 8'd0);
      checks++; if (bus.DROP_STICKY !== ((c >= 4) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL drop_sticky c%0d: got %b", c, bus.DROP_STICKY); end
      checks++; if (bus.DROP_COUNT !== exp_cnt) begin errors++; $display("FAIL drop_count c%0d: got %0d expected %0d", c, bus.DROP_COUNT, exp_cnt); end
      checks++; if (bus.SYNC_EVENT !== (c == 11)) begin errors++; $display("FAIL drop_event c%0d: got %0b expected %0b", c, bus.SYNC_EVENT, (c == 11)); end
      if (bus.SYNC_EVENT === 1'b1) events++;
      if (c == 11) begin
        checks++; if (bus.SYNC_ID !== 2'd1) begin errors++; $display("FAIL drop_id c11: got %0d expected 1", bus.SYNC_ID); end
      end
      tick();
    end
    checks++; if (events != 1) begin errors++; $display("FAIL drop_event_total: got %0d expected 1", events); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.ENABLE = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      bus.REQ_PULSE = (c <= 1) ? 4'b0001 : 4'b0000;
      @(negedge CLK);
      checks++; if (bus.SYNC_EVENT !== (c == 2 || c == 11)) begin errors++; $display("FAIL b2b_event c%0d: got %0b", c, bus.SYNC_EVENT); end
      if (c == 2 || c == 11) begin
        checks++; if (bus.SYNC_ID !== 2'd0) begin errors++; $display("FAIL b2b_id c%0d: got %0d expected 0", c, bus.SYNC_ID); end
      end
      checks++; if (bus.DROP_COUNT !== 8'd0) begin errors++; $display("FAIL b2b_count c%0d: got %0d expected 0", c, bus.DROP_COUNT); end
      tick();
    end
    checks++; if (bus.DROP_STICKY !== 4'b0000) begin errors++; $display("FAIL b2b_sticky: got %b expected 0000", bus.DROP_STICKY); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.ENABLE = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      bus.REQ_PULSE = (c == 0) ? 4'b1111 : 4'b0000;
      @(negedge CLK);
      if (c == 4) begin
        checks++; if (bus.SYNC_BUSY !== 1'b1 || bus.PENDING !== 4'b1110) begin errors++; $display("FAIL rmid_pre c4: busy %0b pending %b expected 1 1110", bus.SYNC_BUSY, bus.PENDING); end
      end
      tick();
    end
    RESET = 1'b1;
    #1;
    checks++; if (bus.SYNC_BUSY !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b expected 0", bus.SYNC_BUSY); end
    checks++; if (bus.PENDING !== 4'b0000) begin errors++; $display("FAIL rmid_pending: got %b expected 0000", bus.PENDING); end
    checks++; if (bus.SYNC_EVENT !== 1'b0 || bus.SYNC_ID !== 2'd0) begin errors++; $display("FAIL rmid_evt_id: got %0b %0d expected 0 0", bus.SYNC_EVENT, bus.SYNC_ID); end
    tick();
    RESET = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      bus.REQ_PULSE = (c == 0) ? 4'b1001 : 4'b0000;
      @(negedge CLK);
      checks++; if (bus.SYNC_EVENT !== (c == 2 || c == 11)) begin errors++; $display("FAIL rmid_event c%0d: got %0b", c, bus.SYNC_EVENT); end
      if (c == 2) begin
        checks++; if (bus.SYNC_ID !== 2'd0) begin errors++; $display("FAIL rmid_ptr_id c2: got %0d expected 0", bus.SYNC_ID); end
      end
      if (c == 11) begin
        checks++; if (bus.SYNC_ID !== 2'd3) begin errors++; $display("FAIL rmid_id3 c11: got %0d expected 3", bus.SYNC_ID); end
      end
      tick();
    end
  endtask

  task automatic test_drop_clr();
    apply_reset();
    for (int c = 0; c <= 9; c++) begin
      bus.REQ_PULSE = (c <= 6) ? 4'b0100 : 4'b0000;
      bus.DROP_CLR  = (c == 6 || c == 8);
      @(negedge CLK);
      if (c == 6) begin
        checks++; if (bus.DROP_COUNT !== 8'd5) begin errors++; $display("FAIL clr_pre_count: got %0d expected 5", bus.DROP_COUNT); end
      end
      if (c == 7) begin
        checks++; if (bus.DROP_COUNT !== 8'd1) begin errors++; $display("FAIL clr_wins_count: got %0d expected 1", bus.DROP_COUNT); end
        checks++; if (bus.DROP_STICKY !== 4'b0100) begin errors++; $display("FAIL clr_wins_sticky: got %b expected 0100", bus.DROP_STICKY); end
      end
      if (c == 9) begin
        checks++; if (bus.DROP_COUNT !== 8'd0 || bus.DROP_STICKY !== 4'b0000) begin errors++; $display("FAIL clr_only: got %0d %b expected 0 0000", bus.DROP_COUNT, bus.DROP_STICKY); end
      end
      tick();
    end
    bus.DROP_CLR = 1'b0;
  endtask

  task automatic test_saturate();
    apply_reset();
    bus.REQ_PULSE = 4'b0001;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      if (c == 255) begin
        checks++; if (bus.DROP_COUNT !== 8'd254) begin errors++; $display("FAIL sat_pre: got %0d expected 254", bus.DROP_COUNT); end
      end
      tick();
    end
    bus.REQ_PULSE = 4'b0000;
    @(negedge CLK);
    checks++; if (bus.DROP_COUNT !== 8'hFF) begin errors++; $display("FAIL sat_count: got %0d expected 255", bus.DROP_COUNT); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_drop_enable();
    test_back_to_back();
    test_reset_mid();
    test_drop_clr();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
